// File: rtl/ppi_bus_master.sv
// Clocked initiator for the 8255-style PPI bus: turns valid/ready commands into
// timed CS/READ/WRITE cycles and returns read data on a one-cycle response strobe.
module ppi_bus_master #(
    parameter int         T_SETUP   = 1,
    parameter int         T_STROBE  = 2,
    parameter int         T_HOLD    = 1,
    parameter int         T_RECOVER = 1,
    parameter bit         INIT_EN   = 1'b1,
    parameter logic [7:0] INIT_CTRL = 8'h9B
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [1:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic [1:0] A,
    output logic       CS,
    output logic       READ,
    output logic       WRITE,
    inout  wire  [7:0] DATA
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_RECOVER,
        S_RDCTL
    } state_t;

    localparam logic [7:0] CNT_SETUP   = 8'(T_SETUP - 1);
    localparam logic [7:0] CNT_STROBE  = 8'(T_STROBE - 1);
    localparam logic [7:0] CNT_HOLD    = 8'(T_HOLD - 1);
    localparam logic [7:0] CNT_RECOVER = 8'(T_RECOVER - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       w_accept;

    logic       r_cmd_write;
    logic [1:0] r_cmd_addr;
    logic [7:0] r_cmd_wdata;

    logic       r_cs;
    logic       r_rd;
    logic       r_wr;
    logic [1:0] r_a;
    logic       r_drive;
    logic [7:0] r_dout;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_rdata;

    logic       w_on_bus;

    // NOTE: state and counter are registered with <= only; the next values come
    // from the combinational block below so every edge sees one consistent snapshot.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= INIT_EN ? S_INIT : S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = (r_cnt != 8'd0) ? r_cnt - 8'd1 : 8'd0;
        w_accept     = 1'b0;
        case (r_state)
            S_INIT: begin
                w_state_next = S_SETUP;
                w_cnt_next   = CNT_SETUP;
            end
            S_IDLE: begin
                w_cnt_next = 8'd0;
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    // The PPI cannot read its control register, so answer locally.
                    if (!cmd_write && cmd_addr == 2'd3) begin
                        w_state_next = S_RDCTL;
                    end else begin
                        w_state_next = S_SETUP;
                        w_cnt_next   = CNT_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = S_STROBE;
                    w_cnt_next   = CNT_STROBE;
                end
            end
            S_STROBE: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = S_HOLD;
                    w_cnt_next   = CNT_HOLD;
                end
            end
            S_HOLD: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = S_RECOVER;
                    w_cnt_next   = CNT_RECOVER;
                end
            end
            S_RECOVER: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = S_IDLE;
                end
            end
            S_RDCTL: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 8'd0;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    // Command latch; reset preloads the automatic control-word write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cmd_write <= 1'b1;
            r_cmd_addr  <= 2'd3;
            r_cmd_wdata <= INIT_CTRL;
        end else if (w_accept) begin
            r_cmd_write <= cmd_write;
            r_cmd_addr  <= cmd_addr;
            r_cmd_wdata <= cmd_wdata;
        end
    end

    assign w_on_bus = (r_state == S_SETUP) || (r_state == S_STROBE) || (r_state == S_HOLD);

    // Pins are registered from the state, so they trail the state register by one cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cs        <= 1'b1;
            r_rd        <= 1'b1;
            r_wr        <= 1'b1;
            r_a         <= 2'd0;
            r_drive     <= 1'b0;
            r_dout      <= 8'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'd0;
        end else begin
            r_cs        <= !w_on_bus;
            r_rd        <= !(r_state == S_STROBE && !r_cmd_write);
            r_wr        <= !(r_state == S_STROBE && r_cmd_write);
            r_drive     <= w_on_bus && r_cmd_write;
            r_dout      <= r_cmd_wdata;
            r_rsp_valid <= 1'b0;
            if (w_on_bus) begin
                r_a <= r_cmd_addr;
            end
            // First HOLD cycle in the state register is the last READ-low cycle on the pins.
            if (r_state == S_HOLD && r_cnt == CNT_HOLD && !r_cmd_write) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= DATA;
            end
            if (r_state == S_RDCTL) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= 8'hFF;
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign A         = r_a;
    assign CS        = r_cs;
    assign READ      = r_rd;
    assign WRITE     = r_wr;
    assign DATA      = r_drive ? r_dout : 8'hzz;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Directed bench for ppi_bus_master: bus-cycle traces checked against timing rules,
// read data checked through a response scoreboard.
module tb_ppi_bus_master;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic [1:0] A;
    logic       CS;
    logic       READ;
    logic       WRITE;
    wire  [7:0] DATA;

    logic [7:0] tb_rdval;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb[$];

    logic       cs_t[32];
    logic       rd_t[32];
    logic       wr_t[32];
    logic       rdy_t[32];
    logic       rv_t[32];
    logic [1:0] a_t[32];
    int         n_cs_low;
    int         n_rd_low;
    int         n_wr_low;
    int         n_rv;
    int         n_dmatch;
    int         first_rdy;

    ppi_bus_master dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .A         (A),
        .CS        (CS),
        .READ      (READ),
        .WRITE     (WRITE),
        .DATA      (DATA)
    );

    // Peripheral model: drives read data only while READ is low.
    assign DATA = (READ == 1'b0) ? tb_rdval : 8'hzz;

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response scoreboard: every rsp_valid pulse must match the oldest expected value.
    always @(negedge CLK) begin
        if (rsp_valid === 1'b1) begin
            check("rsp_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                check("rsp_rdata", 32'(rsp_rdata), 32'(sb.pop_front()));
            end
        end
    end

    task automatic capture(input int n, input logic [7:0] dexp);
        n_cs_low  = 0;
        n_rd_low  = 0;
        n_wr_low  = 0;
        n_rv      = 0;
        n_dmatch  = 0;
        first_rdy = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            cs_t[i]  = CS;
            rd_t[i]  = READ;
            wr_t[i]  = WRITE;
            rdy_t[i] = cmd_ready;
            rv_t[i]  = rsp_valid;
            a_t[i]   = A;
            if (CS == 1'b0) n_cs_low++;
            if (READ == 1'b0) n_rd_low++;
            if (WRITE == 1'b0) n_wr_low++;
            if (rsp_valid == 1'b1) n_rv++;
            if (CS == 1'b0 && DATA === dexp) n_dmatch++;
            if (cmd_ready == 1'b1 && first_rdy < 0) first_rdy = i;
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) @(negedge CLK);
        check("ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    // Issue one command from a negedge; returns 2 time units after the accepting edge.
    task automatic send(input logic w, input logic [1:0] a, input logic [7:0] d);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(posedge CLK);
        #2;
        cmd_valid = 1'b0;
        cmd_write = ~w;
        cmd_addr  = ~a;
        cmd_wdata = ~d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cs_hi;
        RESET     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 2'd0;
        cmd_wdata = 8'd0;
        tb_rdval  = 8'h00;

        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_cs", 32'(CS), 32'd1);
        check("rst_read", 32'(READ), 32'd1);
        check("rst_write", 32'(WRITE), 32'd1);
        check("rst_a", 32'(A), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        // Automatic control-word write after release
        RESET = 1'b0;
        capture(8, 8'h9B);
        check("init_cs_low", 32'(n_cs_low), 32'd4);
        check("init_wr_low", 32'(n_wr_low), 32'd2);
        check("init_rd_low", 32'(n_rd_low), 32'd0);
        check("init_a", 32'(a_t[1]), 32'd3);
        check("init_data", 32'(n_dmatch), 32'd4);
        check("init_wr_first", 32'(wr_t[2]), 32'd0);
        check("init_ready_idx", 32'(first_rdy), 32'd5);
        check("init_rsp", 32'(n_rv), 32'd0);

        // Write addr 0, data 5A
        send(1'b1, 2'd0, 8'h5A);
        capture(8, 8'h5A);
        check("wr_cs_low", 32'(n_cs_low), 32'd4);
        check("wr_cs_first", 32'(cs_t[1]), 32'd0);
        check("wr_wr_low", 32'(n_wr_low), 32'd2);
        check("wr_wr_idx", 32'({wr_t[1], wr_t[2], wr_t[3], wr_t[4]}), 32'b1001);
        check("wr_data", 32'(n_dmatch), 32'd4);
        check("wr_a", 32'(a_t[2]), 32'd0);
        check("wr_rsp", 32'(n_rv), 32'd0);
        check("wr_ready_idx", 32'(first_rdy), 32'd5);

        // Read addr 1, peripheral returns C3
        tb_rdval = 8'hC3;
        sb.push_back(8'hC3);
        send(1'b0, 2'd1, 8'h00);
        capture(8, 8'h00);
        check("rd_cs_low", 32'(n_cs_low), 32'd4);
        check("rd_rd_low", 32'(n_rd_low), 32'd2);
        check("rd_rd_idx", 32'({rd_t[1], rd_t[2], rd_t[3], rd_t[4]}), 32'b1001);
        check("rd_wr_low", 32'(n_wr_low), 32'd0);
        check("rd_a", 32'(a_t[3]), 32'd1);
        check("rd_rsp_cnt", 32'(n_rv), 32'd1);
        check("rd_rsp_idx", 32'(rv_t[4]), 32'd1);
        check("rd_rdata_held", 32'(rsp_rdata), 32'hC3);

        // Back-to-back reads with cmd_valid held
        tb_rdval = 8'h3C;
        sb.push_back(8'h3C);
        sb.push_back(8'h3C);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 2'd2;
        capture(11, 8'h00);
        cmd_valid = 1'b0;
        cs_hi = 0;
        for (int i = 5; i < 11; i++) if (cs_t[i] == 1'b1) cs_hi++;
        check("b2b_ready_idx", 32'(first_rdy), 32'd5);
        check("b2b_ready_once", 32'(rdy_t[6]), 32'd0);
        check("b2b_cs_gap", 32'(cs_hi), 32'd2);
        check("b2b_cs_relow", 32'(cs_t[7]), 32'd0);
        check("b2b_rsp_cnt", 32'(n_rv), 32'd2);
        check("b2b_rsp2_idx", 32'(rv_t[10]), 32'd1);
        capture(6, 8'h00);

        // Control-register read shortcut
        sb.push_back(8'hFF);
        send(1'b0, 2'd3, 8'h00);
        capture(6, 8'h00);
        check("ctl_cs_low", 32'(n_cs_low), 32'd0);
        check("ctl_rd_low", 32'(n_rd_low), 32'd0);
        check("ctl_rsp_idx", 32'(rv_t[1]), 32'd1);
        check("ctl_rsp_cnt", 32'(n_rv), 32'd1);
        check("ctl_ready_idx", 32'(first_rdy), 32'd1);
        check("ctl_rdata", 32'(rsp_rdata), 32'hFF);

        // Reset in the middle of a read strobe: response dropped, init write reissued
        tb_rdval = 8'hA5;
        send(1'b0, 2'd1, 8'h00);
        capture(3, 8'h00);
        check("mid_read_low", 32'(rd_t[2]), 32'd0);
        RESET = 1'b1;
        @(negedge CLK);
        check("mid_read_high", 32'(READ), 32'd1);
        check("mid_cs_high", 32'(CS), 32'd1);
        check("mid_rsp", 32'(rsp_valid), 32'd0);
        check("mid_ready", 32'(cmd_ready), 32'd0);
        @(negedge CLK);
        check("mid_rsp2", 32'(rsp_valid), 32'd0);
        RESET = 1'b0;
        capture(8, 8'h9B);
        check("reinit_wr_low", 32'(n_wr_low), 32'd2);
        check("reinit_a", 32'(a_t[1]), 32'd3);
        check("reinit_data", 32'(n_dmatch), 32'd4);
        check("reinit_rsp", 32'(n_rv), 32'd0);
        check("reinit_ready_idx", 32'(first_rdy), 32'd5);

        repeat (3) @(negedge CLK);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
